// File: rtl/dcache_pkg.sv
// Shared types and defaults for the write-through, no-write-allocate data cache.
// Bus command encoding, line/MSHR records and the block-address helper live here.
package dcache_pkg;

   typedef enum logic [1:0] {
      BUS_NONE  = 2'd0,
      BUS_LOAD  = 2'd1,
      BUS_STORE = 2'd2
   } bus_command_t;

   localparam int DCACHE_NUM_LINES = 32;
   localparam int DCACHE_IDX_W     = 5;
   localparam int DCACHE_NUM_MSHR  = 4;
   localparam int MEM_TAG_W        = 4;
   localparam int MSHR_ENTRIES     = 16;
   localparam int BLOCK_W          = 29;

   // Line tag is the block address shifted right by IDX_W and zero-extended.
   typedef struct packed {
      logic               valid;
      logic [BLOCK_W-1:0] tag;
      logic [63:0]        data;
   } dcache_line_t;

   typedef struct packed {
      logic               valid;
      logic               stale;
      logic [BLOCK_W-1:0] block_addr;
   } dcache_mshr_t;

   function automatic logic [BLOCK_W-1:0] block_of(input logic [31:0] addr);
      return addr[31:3];
   endfunction

endpackage

// File: rtl/dcache_if.sv
// LSQ-side and memory-side signals of the data cache, bundled for port connection.
// Handshake: a request is taken when dcache_response is nonzero or dcache_hit is 1; otherwise the LSQ retries.
interface dcache_if;
   import dcache_pkg::*;

   bus_command_t lsq_command;
   logic [31:0]  lsq_addr;
   logic [63:0]  lsq_data;
   logic [3:0]   dcache_response;
   logic         dcache_hit;
   logic [63:0]  dcache_data_out;
   logic [3:0]   dcache_tag;
   bus_command_t proc2mem_command;
   logic [31:0]  proc2mem_addr;
   logic [63:0]  proc2mem_data;
   logic [3:0]   mem2proc_response;
   logic [63:0]  mem2proc_data;
   logic [3:0]   mem2proc_tag;

   // master: the LSQ and memory environment; slave: the cache itself
   modport master (
      output lsq_command, lsq_addr, lsq_data,
      output mem2proc_response, mem2proc_data, mem2proc_tag,
      input  dcache_response, dcache_hit, dcache_data_out, dcache_tag,
      input  proc2mem_command, proc2mem_addr, proc2mem_data
   );

   modport slave (
      input  lsq_command, lsq_addr, lsq_data,
      input  mem2proc_response, mem2proc_data, mem2proc_tag,
      output dcache_response, dcache_hit, dcache_data_out, dcache_tag,
      output proc2mem_command, proc2mem_addr, proc2mem_data
   );

endinterface

// File: rtl/dcache_mshr.sv
// Miss-status table indexed by memory tag (entry 0 never used) with stale marking
// for stores that overtake an outstanding load, plus an occupancy counter.
module dcache_mshr
   import dcache_pkg::*;
#(
   parameter  int NUM_MSHR = DCACHE_NUM_MSHR,
   localparam int CNT_W    = $clog2(NUM_MSHR + 1)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [MEM_TAG_W-1:0] fill_tag,
   output logic                 fill_hit,
   output logic                 fill_stale,
   output logic [BLOCK_W-1:0]   fill_addr,
   input  logic                 alloc_en,
   input  logic [MEM_TAG_W-1:0] alloc_tag,
   input  logic [BLOCK_W-1:0]   alloc_addr,
   input  logic                 stale_en,
   input  logic [BLOCK_W-1:0]   stale_addr,
   output logic                 full
);

   dcache_mshr_t entries [MSHR_ENTRIES];
   logic [CNT_W-1:0] count;

   assign fill_hit   = (fill_tag != '0) && entries[fill_tag].valid;
   assign fill_stale = entries[fill_tag].stale;
   assign fill_addr  = entries[fill_tag].block_addr;
   assign full       = (count == CNT_W'(NUM_MSHR));

   // Later assignments win: fill clears first, so a same-cycle reissue of the tag survives.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < MSHR_ENTRIES; i++) begin
            entries[i].valid <= 1'b0;
            entries[i].stale <= 1'b0;
         end
         count <= '0;
      end else begin
         if (stale_en) begin
            for (int i = 0; i < MSHR_ENTRIES; i++) begin
               if (entries[i].valid && entries[i].block_addr == stale_addr)
                  entries[i].stale <= 1'b1;
            end
         end
         if (fill_hit)
            entries[fill_tag].valid <= 1'b0;
         if (alloc_en)
            entries[alloc_tag] <= '{valid: 1'b1, stale: 1'b0, block_addr: alloc_addr};
         if (alloc_en && !fill_hit && !full)
            count <= count + CNT_W'(1);
         else if (fill_hit && !alloc_en && count != '0)
            count <= count - CNT_W'(1);
      end
   end

endmodule

// File: rtl/dcache.sv
// Direct-mapped, write-through, no-write-allocate data cache with combinational hits
// and non-blocking load misses tracked by memory tag.
module dcache
   import dcache_pkg::*;
#(
   parameter int NUM_LINES = DCACHE_NUM_LINES,
   parameter int IDX_W     = DCACHE_IDX_W,
   parameter int NUM_MSHR  = DCACHE_NUM_MSHR
) (
   input logic     clk,
   input logic     reset,
   dcache_if.slave bus
);

   dcache_line_t lines_q [NUM_LINES];

   logic [BLOCK_W-1:0] req_block;
   logic [IDX_W-1:0]   req_idx;
   logic [BLOCK_W-1:0] req_tag;
   logic               unused_offset;

   logic               mshr_fill_hit;
   logic               fill_stale;
   logic [BLOCK_W-1:0] fill_addr;
   logic [IDX_W-1:0]   fill_idx;
   logic [BLOCK_W-1:0] fill_line_tag;
   logic               mshr_full;

   logic fill_now;
   logic fill_install;
   logic is_load;
   logic is_store;
   logic line_hit;
   logic store_accept;
   logic store_hit;
   logic alloc_en;

   assign req_block     = block_of(bus.lsq_addr);
   assign req_idx       = req_block[IDX_W-1:0];
   assign req_tag       = req_block >> IDX_W;
   assign unused_offset = ^bus.lsq_addr[2:0];

   assign fill_idx      = fill_addr[IDX_W-1:0];
   assign fill_line_tag = fill_addr >> IDX_W;

   assign fill_now     = mshr_fill_hit && !reset;
   assign fill_install = fill_now && !fill_stale;
   assign is_load      = !reset && (bus.lsq_command == BUS_LOAD);
   assign is_store     = !reset && (bus.lsq_command == BUS_STORE);
   assign line_hit     = lines_q[req_idx].valid && (lines_q[req_idx].tag == req_tag);
   assign store_accept = is_store && (bus.mem2proc_response != '0);

   // A store sees the line as it stands after this cycle's fill install.
   assign store_hit = (fill_install && fill_idx == req_idx) ? (fill_line_tag == req_tag)
                                                            : line_hit;

   assign alloc_en = is_load && !fill_now && !line_hit && !mshr_full &&
                     (bus.mem2proc_response != '0);

   dcache_mshr #(
      .NUM_MSHR (NUM_MSHR)
   ) u_mshr (
      .clk        (clk),
      .reset      (reset),
      .fill_tag   (bus.mem2proc_tag),
      .fill_hit   (mshr_fill_hit),
      .fill_stale (fill_stale),
      .fill_addr  (fill_addr),
      .alloc_en   (alloc_en),
      .alloc_tag  (bus.mem2proc_response),
      .alloc_addr (req_block),
      .stale_en   (store_accept),
      .stale_addr (req_block),
      .full       (mshr_full)
   );

   // dcache_data_out has a single source per cycle: fill data blocks load hits.
   always_comb begin
      bus.dcache_response  = '0;
      bus.dcache_hit       = 1'b0;
      bus.dcache_data_out  = '0;
      bus.dcache_tag       = '0;
      bus.proc2mem_command = BUS_NONE;
      bus.proc2mem_addr    = '0;
      bus.proc2mem_data    = '0;
      if (fill_now) begin
         bus.dcache_tag      = bus.mem2proc_tag;
         bus.dcache_data_out = bus.mem2proc_data;
      end
      if (is_store) begin
         bus.proc2mem_command = BUS_STORE;
         bus.proc2mem_addr    = {req_block, 3'b000};
         bus.proc2mem_data    = bus.lsq_data;
         bus.dcache_response  = bus.mem2proc_response;
      end else if (is_load && !fill_now) begin
         if (line_hit) begin
            bus.dcache_hit      = 1'b1;
            bus.dcache_data_out = lines_q[req_idx].data;
         end else if (!mshr_full) begin
            bus.proc2mem_command = BUS_LOAD;
            bus.proc2mem_addr    = {req_block, 3'b000};
            bus.dcache_response  = bus.mem2proc_response;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NUM_LINES; i++)
            lines_q[i].valid <= 1'b0;
      end else begin
         if (fill_install)
            lines_q[fill_idx] <= '{valid: 1'b1, tag: fill_line_tag, data: bus.mem2proc_data};
         if (store_accept && store_hit)
            lines_q[req_idx].data <= bus.lsq_data;
      end
   end

endmodule

// File: tb/tb_dcache.sv
// Bench for dcache: directed scenarios plus a randomized run against a block-level
// model (cached blocks and outstanding misses held in associative arrays).
module tb_dcache;
   import dcache_pkg::*;

   localparam int N_LINES = 32;
   localparam int N_MSHR  = 4;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   dcache_if bus();

   dcache dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // Reference state: data of each cached block, and outstanding misses by memory tag.
   logic [63:0] cache_m [logic [28:0]];
   logic [28:0] pend_blk [int];
   bit          pend_stale [int];

   int n_cmp  = 0;
   int n_fail = 0;
   logic [170:0] exp_vec;

   function automatic logic [170:0] obs_vec();
      return {bus.dcache_response, bus.dcache_hit, bus.dcache_data_out, bus.dcache_tag,
              bus.proc2mem_command, bus.proc2mem_addr, bus.proc2mem_data};
   endfunction

   task automatic install(input logic [28:0] b, input logic [63:0] d);
      logic [28:0] victims [$];
      foreach (cache_m[k])
         if ((k % N_LINES) == (b % N_LINES)) victims.push_back(k);
      foreach (victims[i]) cache_m.delete(victims[i]);
      cache_m[b] = d;
   endtask

   function automatic logic [170:0] predict();
      logic [3:0]  resp  = '0;
      logic        hit   = 1'b0;
      logic [63:0] dout  = '0;
      logic [3:0]  dtag  = '0;
      logic [1:0]  pcmd  = BUS_NONE;
      logic [31:0] paddr = '0;
      logic [63:0] pdata = '0;
      logic [28:0] b;
      bit          fill;
      b    = bus.lsq_addr >> 3;
      fill = (bus.mem2proc_tag != 0) && pend_blk.exists(int'(bus.mem2proc_tag));
      if (!reset) begin
         if (fill) begin
            dtag = bus.mem2proc_tag;
            dout = bus.mem2proc_data;
         end
         if (bus.lsq_command == BUS_STORE) begin
            pcmd  = BUS_STORE;
            paddr = {b, 3'b000};
            pdata = bus.lsq_data;
            resp  = bus.mem2proc_response;
         end else if (bus.lsq_command == BUS_LOAD && !fill) begin
            if (cache_m.exists(b)) begin
               hit  = 1'b1;
               dout = cache_m[b];
            end else if (pend_blk.num() < N_MSHR) begin
               pcmd  = BUS_LOAD;
               paddr = {b, 3'b000};
               resp  = bus.mem2proc_response;
            end
         end
      end
      return {resp, hit, dout, dtag, pcmd, paddr, pdata};
   endfunction

   // Applies the effect of the inputs held across the clock edge just taken.
   task automatic commit();
      logic [28:0] b;
      int  t;
      bit  fill;
      b = bus.lsq_addr >> 3;
      t = int'(bus.mem2proc_tag);
      if (reset) begin
         cache_m.delete();
         pend_blk.delete();
         pend_stale.delete();
         return;
      end
      fill = (t != 0) && pend_blk.exists(t);
      if (fill) begin
         if (!pend_stale[t]) install(pend_blk[t], bus.mem2proc_data);
         pend_blk.delete(t);
         pend_stale.delete(t);
      end
      if (bus.lsq_command == BUS_STORE && bus.mem2proc_response != 0) begin
         foreach (pend_blk[k])
            if (pend_blk[k] == b) pend_stale[k] = 1'b1;
         if (cache_m.exists(b)) cache_m[b] = bus.lsq_data;
      end else if (bus.lsq_command == BUS_LOAD && !fill && !cache_m.exists(b) &&
                   pend_blk.num() < N_MSHR && bus.mem2proc_response != 0) begin
         pend_blk[int'(bus.mem2proc_response)]   = b;
         pend_stale[int'(bus.mem2proc_response)] = 1'b0;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      commit();
      #1;
   endtask

   task automatic apply(input logic rst, input bus_command_t cmd, input logic [31:0] addr,
                        input logic [63:0] d, input logic [3:0] mresp,
                        input logic [3:0] mtag, input logic [63:0] mdata);
      reset                 = rst;
      bus.lsq_command       = cmd;
      bus.lsq_addr          = addr;
      bus.lsq_data          = d;
      bus.mem2proc_response = mresp;
      bus.mem2proc_tag      = mtag;
      bus.mem2proc_data     = mdata;
      exp_vec = predict();
      #2;
   endtask

   task automatic drive(input logic rst, input bus_command_t cmd, input logic [31:0] addr,
                        input logic [63:0] d, input logic [3:0] mresp,
                        input logic [3:0] mtag, input logic [63:0] mdata);
      tick();
      apply(rst, cmd, addr, d, mresp, mtag, mdata);
   endtask

   task automatic test_reset();
      drive(1'b1, BUS_LOAD, 32'h100, 64'h1, 4'd3, 4'd0, 64'h0);
      drive(1'b1, BUS_STORE, 32'h200, 64'h5, 4'd2, 4'd1, 64'h7);
      if (obs_vec() !== '0) begin n_fail++; $display("FAIL reset_outputs: got %h want 0", obs_vec()); end n_cmp++;
      drive(1'b0, BUS_NONE, 32'h0, 64'h0, 4'd0, 4'd0, 64'h0);
      if (obs_vec() !== exp_vec) begin n_fail++; $display("FAIL reset_idle: got %h want %h", obs_vec(), exp_vec); end n_cmp++;
   endtask

   task automatic test_cold_miss_fill_hit();
      drive(1'b0, BUS_LOAD, 32'h100, 64'h0, 4'd3, 4'd0, 64'h0);
      if (obs_vec() !== exp_vec) begin n_fail++; $display("FAIL cold_miss: got %h want %h", obs_vec(), exp_vec); end n_cmp++;
      if (bus.dcache_response !== 4'd3 || bus.proc2mem_command !== BUS_LOAD || bus.proc2mem_addr !== 32'h100 || bus.dcache_hit !== 1'b0) begin
         n_fail++; $display("FAIL cold_miss_req: got resp=%0d cmd=%0d addr=%h hit=%b want 3 1 00000100 0", bus.dcache_response, bus.proc2mem_command, bus.proc2mem_addr, bus.dcache_hit);
      end n_cmp++;
      drive(1'b0, BUS_NONE, 32'h0, 64'h0, 4'd0, 4'd0, 64'h0);
      drive(1'b0, BUS_NONE, 32'h0, 64'h0, 4'd0, 4'd3, 64'hAAAA_BBBB_CCCC_DDDD);
      if (bus.dcache_tag !== 4'd3 || bus.dcache_data_out !== 64'hAAAA_BBBB_CCCC_DDDD) begin
         n_fail++; $display("FAIL fill_return: got tag=%0d data=%h want 3 aaaabbbbccccdddd", bus.dcache_tag, bus.dcache_data_out);
      end n_cmp++;
      drive(1'b0, BUS_LOAD, 32'h104, 64'h0, 4'd6, 4'd0, 64'h0);
      if (obs_vec() !== exp_vec) begin n_fail++; $display("FAIL reload_hit: got %h want %h", obs_vec(), exp_vec); end n_cmp++;
      if (bus.dcache_hit !== 1'b1 || bus.dcache_data_out !== 64'hAAAA_BBBB_CCCC_DDDD || bus.dcache_response !== 4'd0 || bus.proc2mem_command !== BUS_NONE) begin
         n_fail++; $display("FAIL reload_hit_fields: got hit=%b data=%h resp=%0d cmd=%0d", bus.dcache_hit, bus.dcache_data_out, bus.dcache_response, bus.proc2mem_command);
      end n_cmp++;
   endtask

   task automatic test_mshr_full();
      logic [31:0] addrs [4];
      addrs = '{32'h1000, 32'h2008, 32'h3010, 32'h4018};
      for (int i = 0; i < 4; i++) begin
         drive(1'b0, BUS_LOAD, addrs[i], 64'h0, 4'(i + 1), 4'd0, 64'h0);
         if (obs_vec() !== exp_vec) begin n_fail++; $display("FAIL full_fill_up%0d: got %h want %h", i, obs_vec(), exp_vec); end n_cmp++;
      end
      drive(1'b0, BUS_LOAD, 32'h5020, 64'h0, 4'd5, 4'd0, 64'h0);
      if (bus.dcache_response !== 4'd0 || bus.proc2mem_command !== BUS_NONE || bus.dcache_hit !== 1'b0) begin
         n_fail++; $display("FAIL full_reject: got resp=%0d cmd=%0d hit=%b want 0 0 0", bus.dcache_response, bus.proc2mem_command, bus.dcache_hit);
      end n_cmp++;
      drive(1'b0, BUS_NONE, 32'h0, 64'h0, 4'd0, 4'd2, 64'h2222);
      drive(1'b0, BUS_LOAD, 32'h5020, 64'h0, 4'd5, 4'd0, 64'h0);
      if (bus.dcache_response !== 4'd5 || bus.proc2mem_command !== BUS_LOAD || bus.proc2mem_addr !== 32'h5020) begin
         n_fail++; $display("FAIL full_retry: got resp=%0d cmd=%0d addr=%h want 5 1 00005020", bus.dcache_response, bus.proc2mem_command, bus.proc2mem_addr);
      end n_cmp++;
      for (int t = 1; t <= 5; t++) begin
         if (t == 2) continue;
         drive(1'b0, BUS_NONE, 32'h0, 64'h0, 4'd0, 4'(t), 64'(t * 16'h1111));
         if (obs_vec() !== exp_vec) begin n_fail++; $display("FAIL full_drain%0d: got %h want %h", t, obs_vec(), exp_vec); end n_cmp++;
      end
   endtask

   task automatic test_fill_priority();
      drive(1'b0, BUS_LOAD, 32'h308, 64'h0, 4'd1, 4'd0, 64'h0);
      drive(1'b0, BUS_NONE, 32'h0, 64'h0, 4'd0, 4'd1, 64'h3083_0830_8308_3083);
      drive(1'b0, BUS_LOAD, 32'h410, 64'h0, 4'd1, 4'd0, 64'h0);
      drive(1'b0, BUS_LOAD, 32'h308, 64'h0, 4'd2, 4'd1, 64'h4104_1041_0410_4104);
      if (bus.dcache_hit !== 1'b0 || bus.dcache_response !== 4'd0 || bus.dcache_tag !== 4'd1 || bus.dcache_data_out !== 64'h4104_1041_0410_4104) begin
         n_fail++; $display("FAIL fill_blocks_hit: got hit=%b resp=%0d tag=%0d data=%h", bus.dcache_hit, bus.dcache_response, bus.dcache_tag, bus.dcache_data_out);
      end n_cmp++;
      drive(1'b0, BUS_LOAD, 32'h308, 64'h0, 4'd2, 4'd0, 64'h0);
      if (bus.dcache_hit !== 1'b1 || bus.dcache_data_out !== 64'h3083_0830_8308_3083) begin
         n_fail++; $display("FAIL retry_hit: got hit=%b data=%h want 1 3083083083083083", bus.dcache_hit, bus.dcache_data_out);
      end n_cmp++;
   endtask

   task automatic test_store_stale();
      drive(1'b0, BUS_LOAD, 32'h200, 64'h0, 4'd5, 4'd0, 64'h0);
      drive(1'b0, BUS_STORE, 32'h200, 64'h1111, 4'd6, 4'd0, 64'h0);
      if (obs_vec() !== exp_vec) begin n_fail++; $display("FAIL stale_store: got %h want %h", obs_vec(), exp_vec); end n_cmp++;
      if (bus.proc2mem_command !== BUS_STORE || bus.proc2mem_data !== 64'h1111 || bus.dcache_response !== 4'd6) begin
         n_fail++; $display("FAIL stale_store_fields: got cmd=%0d data=%h resp=%0d", bus.proc2mem_command, bus.proc2mem_data, bus.dcache_response);
      end n_cmp++;
      drive(1'b0, BUS_NONE, 32'h0, 64'h0, 4'd0, 4'd5, 64'h0BAD_0BAD_0BAD_0BAD);
      if (bus.dcache_tag !== 4'd5 || bus.dcache_data_out !== 64'h0BAD_0BAD_0BAD_0BAD) begin
         n_fail++; $display("FAIL stale_fill_return: got tag=%0d data=%h", bus.dcache_tag, bus.dcache_data_out);
      end n_cmp++;
      drive(1'b0, BUS_LOAD, 32'h200, 64'h0, 4'd7, 4'd0, 64'h0);
      if (bus.dcache_hit !== 1'b0 || bus.proc2mem_command !== BUS_LOAD || bus.dcache_response !== 4'd7) begin
         n_fail++; $display("FAIL stale_not_installed: got hit=%b cmd=%0d resp=%0d want 0 1 7", bus.dcache_hit, bus.proc2mem_command, bus.dcache_response);
      end n_cmp++;
      drive(1'b0, BUS_NONE, 32'h0, 64'h0, 4'd0, 4'd7, 64'h1111);
   endtask

   task automatic test_store_hit();
      drive(1'b0, BUS_LOAD, 32'h100, 64'h0, 4'd1, 4'd0, 64'h0);
      drive(1'b0, BUS_NONE, 32'h0, 64'h0, 4'd0, 4'd1, 64'h00C0_FFEE);
      drive(1'b0, BUS_STORE, 32'h100, 64'h1234, 4'd2, 4'd0, 64'h0);
      drive(1'b0, BUS_LOAD, 32'h100, 64'h0, 4'd3, 4'd0, 64'h0);
      if (bus.dcache_hit !== 1'b1 || bus.dcache_data_out !== 64'h1234) begin
         n_fail++; $display("FAIL store_hit_update: got hit=%b data=%h want 1 1234", bus.dcache_hit, bus.dcache_data_out);
      end n_cmp++;
      drive(1'b0, BUS_STORE, 32'h100, 64'h5678, 4'd0, 4'd0, 64'h0);
      if (bus.dcache_response !== 4'd0 || bus.proc2mem_command !== BUS_STORE) begin
         n_fail++; $display("FAIL store_reject: got resp=%0d cmd=%0d want 0 2", bus.dcache_response, bus.proc2mem_command);
      end n_cmp++;
      drive(1'b0, BUS_LOAD, 32'h100, 64'h0, 4'd3, 4'd0, 64'h0);
      if (bus.dcache_hit !== 1'b1 || bus.dcache_data_out !== 64'h1234) begin
         n_fail++; $display("FAIL store_reject_keep: got hit=%b data=%h want 1 1234", bus.dcache_hit, bus.dcache_data_out);
      end n_cmp++;
      // Fill install and store to the same block in one cycle: store data must survive.
      drive(1'b0, BUS_LOAD, 32'h600, 64'h0, 4'd3, 4'd0, 64'h0);
      drive(1'b0, BUS_STORE, 32'h600, 64'h5555, 4'd4, 4'd3, 64'hFFFF);
      drive(1'b0, BUS_LOAD, 32'h600, 64'h0, 4'd4, 4'd0, 64'h0);
      if (bus.dcache_hit !== 1'b1 || bus.dcache_data_out !== 64'h5555) begin
         n_fail++; $display("FAIL fill_store_order: got hit=%b data=%h want 1 5555", bus.dcache_hit, bus.dcache_data_out);
      end n_cmp++;
   endtask

   task automatic test_reset_outstanding();
      drive(1'b0, BUS_LOAD, 32'h800, 64'h0, 4'd8, 4'd0, 64'h0);
      drive(1'b0, BUS_LOAD, 32'h900, 64'h0, 4'd9, 4'd0, 64'h0);
      drive(1'b1, BUS_LOAD, 32'h100, 64'h0, 4'd3, 4'd8, 64'h8888);
      if (obs_vec() !== '0) begin n_fail++; $display("FAIL reset_forced: got %h want 0", obs_vec()); end n_cmp++;
      drive(1'b0, BUS_NONE, 32'h0, 64'h0, 4'd0, 4'd8, 64'h8888);
      if (bus.dcache_tag !== 4'd0 || bus.dcache_data_out !== 64'h0) begin
         n_fail++; $display("FAIL late_fill_ignored: got tag=%0d data=%h want 0 0", bus.dcache_tag, bus.dcache_data_out);
      end n_cmp++;
      drive(1'b0, BUS_LOAD, 32'h100, 64'h0, 4'd0, 4'd0, 64'h0);
      if (bus.dcache_hit !== 1'b0 || bus.proc2mem_command !== BUS_LOAD) begin
         n_fail++; $display("FAIL post_reset_miss: got hit=%b cmd=%0d want 0 1", bus.dcache_hit, bus.proc2mem_command);
      end n_cmp++;
   endtask

   function automatic logic [3:0] free_tag();
      int t;
      do t = $urandom_range(1, 15); while (pend_blk.exists(t));
      return 4'(t);
   endfunction

   task automatic test_random();
      bus_command_t cmd;
      logic [31:0]  addr;
      logic [3:0]   mresp;
      logic [3:0]   mtag;
      int           keys [$];
      int           r;
      for (int c = 0; c < 400; c++) begin
         tick();
         r = $urandom_range(0, 99);
         cmd  = (r < 45) ? BUS_LOAD : (r < 75) ? BUS_STORE : BUS_NONE;
         addr = {19'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'd0, 3'($urandom_range(0, 7))};
         addr[31:8] = addr[31:8] & 24'h00_0003;
         addr[7:3]  = 5'($urandom_range(0, 3));
         addr[12:8] = 5'($urandom_range(0, 3));
         mresp = ($urandom_range(0, 9) < 3) ? 4'd0 : free_tag();
         keys.delete();
         foreach (pend_blk[k]) keys.push_back(k);
         r = $urandom_range(0, 99);
         if (r < 40 && keys.size() > 0) mtag = 4'(keys[$urandom_range(0, keys.size() - 1)]);
         else if (r < 50) mtag = free_tag();
         else mtag = 4'd0;
         apply(1'b0, cmd, addr, {$urandom, $urandom}, mresp, mtag, {$urandom, $urandom});
         if (obs_vec() !== exp_vec) begin n_fail++; $display("FAIL random_c%0d: got %h want %h", c, obs_vec(), exp_vec); end n_cmp++;
      end
   endtask

   initial begin
      reset                 = 1'b1;
      bus.lsq_command       = BUS_NONE;
      bus.lsq_addr          = '0;
      bus.lsq_data          = '0;
      bus.mem2proc_response = '0;
      bus.mem2proc_tag      = '0;
      bus.mem2proc_data     = '0;
      exp_vec               = '0;
      test_reset();
      test_cold_miss_fill_hit();
      test_mshr_full();
      test_fill_priority();
      test_store_stale();
      test_store_hit();
      test_reset_outstanding();
      test_random();
      tick();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
